// File: rtl/lane_unstriping_4to1.sv
// Receive-side lane merger: takes one 4-lane word per handshake and emits its
// bytes lane 0 first, using an active + pending word buffer to avoid bubbles.
module lane_unstriping_4to1 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_lane0,
  input  logic [DATA_W-1:0] in_lane1,
  input  logic [DATA_W-1:0] in_lane2,
  input  logic [DATA_W-1:0] in_lane3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_lane,
  output logic              out_last
);

  typedef enum logic [1:0] {EMPTY, SEND, FULL} state_t;

  state_t                   state, state_n;
  logic [3:0][DATA_W-1:0]   active_q, active_n;
  logic [3:0][DATA_W-1:0]   pending_q, pending_n;
  logic [3:0][DATA_W-1:0]   in_word;
  logic [1:0]               lane_idx, lane_idx_n;
  logic                     in_hs, out_hs, word_done;

  assign in_word   = {in_lane3, in_lane2, in_lane1, in_lane0};
  assign in_ready  = reset && (state != FULL);
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign word_done = out_hs && (lane_idx == 2'd3);

  // A word finishing on the same edge a new one arrives hands straight over,
  // so the next lane 0 byte follows the previous lane 3 byte without a gap.
  always_comb begin
    state_n    = state;
    active_n   = active_q;
    pending_n  = pending_q;
    lane_idx_n = out_hs ? lane_idx + 2'd1 : lane_idx;
    case (state)
      EMPTY: begin
        if (in_hs) begin
          active_n   = in_word;
          lane_idx_n = 2'd0;
          state_n    = SEND;
        end
      end
      SEND: begin
        if (word_done) begin
          if (in_hs) begin
            active_n = in_word;
          end else begin
            state_n = EMPTY;
          end
        end else if (in_hs) begin
          pending_n = in_word;
          state_n   = FULL;
        end
      end
      FULL: begin
        if (word_done) begin
          active_n = pending_q;
          state_n  = SEND;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  // Outputs are registered from the next-state values so they change only on clk.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= EMPTY;
      active_q  <= '0;
      pending_q <= '0;
      lane_idx  <= 2'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_lane  <= 2'd0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_n;
      active_q  <= active_n;
      pending_q <= pending_n;
      lane_idx  <= lane_idx_n;
      out_valid <= (state_n != EMPTY);
      out_data  <= active_n[lane_idx_n];
      out_lane  <= lane_idx_n;
      out_last  <= (state_n != EMPTY) && (lane_idx_n == 2'd3);
    end
  end

endmodule

// File: tb/tb_lane_unstriping_4to1.sv
// Scoreboard bench for lane_unstriping_4to1: accepted words are expanded into
// expected bytes; a negedge monitor compares every consumed byte in order.
module tb_lane_unstriping_4to1;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_lane0, in_lane1, in_lane2, in_lane3;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] out_lane;
  logic       out_last;

  typedef struct {
    logic [7:0] data;
    logic [1:0] lane;
    logic       last;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  bit   rand_ready = 0;

  lane_unstriping_4to1 #(.DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_lane0(in_lane0), .in_lane1(in_lane1), .in_lane2(in_lane2), .in_lane3(in_lane3),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_lane(out_lane), .out_last(out_last)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present a word until accepted; the expected bytes are queued on acceptance.
  task automatic applyStimulus(input logic [7:0] l0, input logic [7:0] l1,
                               input logic [7:0] l2, input logic [7:0] l3);
    bit accepted = 0;
    logic [7:0] lanes [4];
    lanes[0] = l0; lanes[1] = l1; lanes[2] = l2; lanes[3] = l3;
    in_valid = 1; in_lane0 = l0; in_lane1 = l1; in_lane2 = l2; in_lane3 = l3;
    for (int t = 0; t < 200 && !accepted; t++) begin
      @(negedge clk);
      if (in_ready) begin
        for (int k = 0; k < 4; k++) sb.push_back('{lanes[k], 2'(k), k == 3});
        accepted = 1;
      end
      @(posedge clk); #1;
    end
    if (!accepted) checkOutput("accept_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic waitDrain();
    int t = 0;
    while ((sb.size() != 0 || out_valid) && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    checkOutput("drain", sb.size(), 0);
  endtask

  // Monitor: compare consumed bytes and verify outputs hold while stalled.
  initial begin
    exp_t e;
    bit prev_stall = 0;
    logic [7:0] h_data; logic [1:0] h_lane; logic h_last;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          checkOutput("hold_valid", out_valid, 1);
          checkOutput("hold_data", out_data, h_data);
          checkOutput("hold_lane", out_lane, h_lane);
          checkOutput("hold_last", out_last, h_last);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_byte", out_data, 0);
          end else begin
            e = sb.pop_front();
            checkOutput("sb_data", out_data, e.data);
            checkOutput("sb_lane", out_lane, e.lane);
            checkOutput("sb_last", out_last, e.last);
          end
        end
        prev_stall = out_valid && !out_ready;
        h_data = out_data; h_lane = out_lane; h_last = out_last;
      end
    end
  end

  always begin
    @(posedge clk); #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    reset = 0; in_valid = 0; out_ready = 1;
    in_lane0 = 0; in_lane1 = 0; in_lane2 = 0; in_lane3 = 0;

    // Reset held for three cycles
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    reset = 1;
    #1;
    checkOutput("rel_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Single word: latency, lane sequence and trailing idle
    applyStimulus(8'h11, 8'h22, 8'h33, 8'h44);
    for (int k = 0; k < 4; k++) begin
      checkOutput("t2_valid", out_valid, 1);
      checkOutput("t2_lane", out_lane, k);
      checkOutput("t2_last", out_last, k == 3);
      @(posedge clk); #1;
    end
    checkOutput("t2_idle", out_valid, 0);
    waitDrain();

    // Back-to-back words: no bubble, in_ready drops while both entries full
    applyStimulus(8'hA0, 8'hA1, 8'hA2, 8'hA3);
    applyStimulus(8'hB0, 8'hB1, 8'hB2, 8'hB3);
    checkOutput("t3_full_ready", in_ready, 0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checkOutput("t3_no_bubble", out_valid, 1);
      checkOutput("t3_in_ready", in_ready, i >= 2);
    end
    waitDrain();

    // Backpressure while lane 2 is shown
    applyStimulus(8'h51, 8'h52, 8'h53, 8'h54);
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("t4_lane", out_lane, 2);
      checkOutput("t4_data", out_data, 8'h53);
    end
    out_ready = 1;
    @(posedge clk); #1;
    checkOutput("t4_resume", out_lane, 3);
    waitDrain();

    // Three words under full backpressure: third stalls until first finishes
    out_ready = 0;
    fork
      begin
        applyStimulus(8'hC0, 8'hC1, 8'hC2, 8'hC3);
        applyStimulus(8'hD0, 8'hD1, 8'hD2, 8'hD3);
        applyStimulus(8'hE0, 8'hE1, 8'hE2, 8'hE3);
      end
    join_none
    repeat (8) @(posedge clk);
    #1;
    checkOutput("t5_stall_ready", in_ready, 0);
    checkOutput("t5_sb_two_words", sb.size(), 8);
    out_ready = 1;
    repeat (20) @(posedge clk);
    #1;
    wait fork;
    waitDrain();

    // Reset mid-word with pending occupied
    applyStimulus(8'h61, 8'h62, 8'h63, 8'h64);
    applyStimulus(8'h71, 8'h72, 8'h73, 8'h74);
    checkOutput("t6_pre_lane", out_lane, 1);
    reset = 0;
    sb.delete();
    @(posedge clk); #1;
    checkOutput("t6_rst_valid", out_valid, 0);
    checkOutput("t6_rst_ready", in_ready, 0);
    reset = 1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checkOutput("t6_no_leftover", out_valid, 0);
    end

    // Randomized traffic with random backpressure
    rand_ready = 1;
    for (int w = 0; w < 40; w++) begin
      applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rand_ready = 0;
    @(posedge clk); #2;
    out_ready = 1;
    waitDrain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
